// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle between a controlling FSM and serial_subtractor.
// Ports: start/a/b flow toward the subtractor; busy/done/diff/bout/ovf flow back.
// Modports: master = controller side, slave = subtractor side.
interface serial_subtractor_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, diff = a - b, one bit per clock LSB first, one shared full-subtractor cell.
// Latency: start sampled at edge k, done pulses in the cycle after edge k+N+1; one operation per N+2 cycles.
// Backpressure: none; start is only honoured in IDLE and ignored while an operation is in flight.
// Ports: clock, reset (sync, active-high); bus (slave modport) carries start/a/b in, busy/done/diff/bout/ovf out.
module serial_subtractor #(
  parameter int N = 8
) (
  input logic              clock,
  input logic              reset,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]  a_sr, b_sr, res_sr;
  logic          borrow_q;
  logic [CW-1:0] cnt;
  logic          a_sign, b_sign;
  logic [N-1:0]  diff_q;
  logic          bout_q, ovf_q, done_q;

  // Shared full-subtractor cell
  logic x, y, w, d, w_next, last;

  assign x      = a_sr[0];
  assign y      = b_sr[0];
  assign w      = borrow_q;
  assign d      = x ^ y ^ w;
  assign w_next = (~x & y) | (~x & w) | (y & w);
  assign last   = (cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last)      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered results
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            borrow_q <= 1'b0;
            cnt      <= '0;
            a_sign   <= bus.a[N-1];
            b_sign   <= bus.b[N-1];
          end
        end
        SHIFT: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          res_sr   <= {d, res_sr[N-1:1]};
          borrow_q <= w_next;
          cnt      <= cnt + CW'(1);
          // Publish on the final bit; d is the result MSB at this point.
          if (last) begin
            diff_q <= {d, res_sr[N-1:1]};
            bout_q <= w_next;
            ovf_q  <= (a_sign != b_sign) & (d != a_sign);
          end
        end
        DONE: done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.N(8)) if8 ();
  serial_subtractor_if #(.N(5)) if5 ();

  serial_subtractor #(.N(8)) dut8 (.clock(clk), .reset(rst), .bus(if8));
  serial_subtractor #(.N(5)) dut5 (.clock(clk), .reset(rst), .bus(if5));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         lat;
    int         nd;
    int         nbusy;
  } res_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Start one operation on both DUTs and observe N+3 cycles after acceptance.
  // c counts negedges after the accepting edge; done belongs at c = N+1.
  task automatic run_both(input logic [7:0] a8, input logic [7:0] b8,
                          input logic [4:0] a5, input logic [4:0] b5,
                          output res_t r8, output res_t r5);
    r8 = '{diff: 8'h0, bout: 1'b0, ovf: 1'b0, lat: -1, nd: 0, nbusy: 0};
    r5 = '{diff: 8'h0, bout: 1'b0, ovf: 1'b0, lat: -1, nd: 0, nbusy: 0};
    @(negedge clk);
    if8.start = 1'b1; if8.a = a8; if8.b = b8;
    if5.start = 1'b1; if5.a = a5; if5.b = b5;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0; if8.a = 8'hxx; if8.b = 8'hxx;
    if5.start = 1'b0; if5.a = 5'hxx; if5.b = 5'hxx;
    for (int c = 0; c <= 12; c++) begin
      if (if8.busy) r8.nbusy++;
      if (if5.busy) r5.nbusy++;
      if (if8.done) begin
        r8.nd++;
        if (r8.lat < 0) begin
          r8.lat = c; r8.diff = if8.diff; r8.bout = if8.bout; r8.ovf = if8.ovf;
        end
      end
      if (if5.done) begin
        r5.nd++;
        if (r5.lat < 0) begin
          r5.lat = c; r5.diff = {3'b000, if5.diff}; r5.bout = if5.bout; r5.ovf = if5.ovf;
        end
      end
      if (c < 12) @(negedge clk);
    end
  endtask

  // Reference subtraction for width n
  task automatic check_model(input string nm, input int n, input logic [7:0] a,
                             input logic [7:0] b, input res_t r);
    int unsigned m, ai, bi, dd;
    logic sa, sb, sd;
    m  = (32'd1 << n) - 1;
    ai = a & m;
    bi = b & m;
    dd = (ai - bi) & m;
    sa = ai[n-1]; sb = bi[n-1]; sd = dd[n-1];
    check({nm, ".diff"}, r.diff, dd);
    check({nm, ".bout"}, r.bout, ai < bi);
    check({nm, ".ovf"},  r.ovf,  (sa != sb) && (sd != sa));
    check({nm, ".lat"},  r.lat,  n + 1);
    check({nm, ".nd"},   r.nd,   1);
    check({nm, ".busy"}, r.nbusy, n);
  endtask

  vec_t vecs[7];
  res_t r8, r5;
  logic [7:0] hold_a[4];
  logic [7:0] hold_b[4];

  initial begin
    vecs[0] = '{a: 8'd200,  b: 8'd55,   diff: 8'd145,  bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'd5,    b: 8'd10,   diff: 8'hFB,   bout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h80,   b: 8'h01,   diff: 8'h7F,   bout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h7F,   b: 8'hFF,   diff: 8'h80,   bout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'h00,   b: 8'h00,   diff: 8'h00,   bout: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 8'hFF,   b: 8'hFF,   diff: 8'h00,   bout: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 8'h01,   b: 8'h02,   diff: 8'hFF,   bout: 1'b1, ovf: 1'b0};

    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if5.start = 1'b0; if5.a = '0; if5.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.busy8", if8.busy, 0);
    check("rst.done8", if8.done, 0);
    check("rst.diff8", if8.diff, 0);
    check("rst.bout8", if8.bout, 0);
    check("rst.ovf8",  if8.ovf,  0);
    check("rst.diff5", if5.diff, 0);
    rst = 1'b0;

    // Directed vectors, hand-computed expectations for N=8
    for (int i = 0; i < 7; i++) begin
      run_both(vecs[i].a, vecs[i].b, vecs[i].a[4:0], vecs[i].b[4:0], r8, r5);
      check($sformatf("vec%0d.diff", i), r8.diff, vecs[i].diff);
      check($sformatf("vec%0d.bout", i), r8.bout, vecs[i].bout);
      check($sformatf("vec%0d.ovf", i),  r8.ovf,  vecs[i].ovf);
      check($sformatf("vec%0d.lat", i),  r8.lat,  9);
      check($sformatf("vec%0d.busy", i), r8.nbusy, 8);
      check($sformatf("vec%0d.nd", i),   r8.nd,   1);
      check_model($sformatf("vec%0d.n5", i), 5, {3'b000, vecs[i].a[4:0]},
                  {3'b000, vecs[i].b[4:0]}, r5);
    end

    // Results stay visible after done
    repeat (3) @(negedge clk);
    check("hold.diff", if8.diff, vecs[6].diff);
    check("hold.done", if8.done, 0);

    // start held high: accepts at edges 0,10,20; done sampled at negedges 10,20,30
    hold_a[0] = 8'd50;  hold_b[0] = 8'd20;
    hold_a[1] = 8'd3;   hold_b[1] = 8'd4;
    hold_a[2] = 8'h90;  hold_b[2] = 8'h20;
    hold_a[3] = 8'd0;   hold_b[3] = 8'd0;
    for (int t = 0; t <= 30; t++) begin
      @(negedge clk);
      check($sformatf("hold.t%0d.done", t), if8.done, (t == 10 || t == 20 || t == 30));
      if (t == 10) check("hold.r0", if8.diff, 8'd30);
      if (t == 20) begin
        check("hold.r1", if8.diff, 8'hFF);
        check("hold.r1.bout", if8.bout, 1'b1);
      end
      if (t == 30) begin
        check("hold.r2", if8.diff, 8'h70);
        check("hold.r2.ovf", if8.ovf, 1'b1);
      end
      if (t < 30) begin
        // Operands change every cycle; only those at the accepting edge count.
        if8.start = 1'b1;
        if (t % 10 == 0) begin
          if8.a = hold_a[t/10]; if8.b = hold_b[t/10];
        end else begin
          if8.a = 8'($urandom); if8.b = 8'($urandom);
        end
      end else begin
        if8.start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    // Reset during SHIFT cycle 4 of 100 - 1
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'd100; if8.b = 8'd1;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", if8.busy, 0);
    check("abort.done", if8.done, 0);
    check("abort.diff", if8.diff, 0);
    check("abort.bout", if8.bout, 0);
    check("abort.ovf",  if8.ovf,  0);
    begin
      int nd;
      nd = 0;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        if (if8.done) nd++;
      end
      check("abort.nodone", nd, 0);
    end
    run_both(8'd9, 8'd3, 5'd9, 5'd3, r8, r5);
    check("post.diff", r8.diff, 8'd6);
    check("post.lat",  r8.lat,  9);
    check_model("post.n5", 5, 8'd9, 8'd3, r5);

    // Random sweep against the reference model, both widths
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_both(ra, rb, ra[4:0], rb[4:0], r8, r5);
      check_model("rnd8", 8, ra, rb, r8);
      check_model("rnd5", 5, {3'b000, ra[4:0]}, {3'b000, rb[4:0]}, r5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, one bit per clock, LSB first.
- A single full-subtractor cell (difference/borrow) is time-shared across all bit positions, with the borrow carried in a flip-flop between cycles.
- Trades latency for area. Intended for datapaths that already serialise operands.
- Start/done handshake to the controlling FSM.

Parameters:
- N, 8, operand and result width in bits (N >= 2).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE; a and b are captured in the same cycle.
- a  input  N  minuend (unsigned or two's complement).
- b  input  N  subtrahend.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  single-cycle pulse; result outputs are valid from this cycle on.
- diff  output  N  a - b modulo 2^N.
- bout  output  1  final borrow out of the MSB (1 = unsigned a < b).
- ovf  output  1  two's-complement overflow of a - b.

Behaviour:
- Reset is synchronous and active-high: on any clock edge with reset=1:
  - state goes to IDLE;
  - busy=0, done=0, diff=0, bout=0, ovf=0;
  - internal shift registers, borrow FF and bit counter are cleared.
- Reset has priority over start and aborts an operation in progress; no done pulse is produced for the aborted operation.
- States and transitions:
  - IDLE -> SHIFT: when start=1.
  - SHIFT -> DONE: after the N-th bit is processed.
  - DONE -> IDLE: unconditional after one cycle.
- IDLE with start=1:
  - latch a into a_sr and b into b_sr;
  - borrow FF = 0, counter = 0;
  - record sign bits a[N-1] and b[N-1];
  - next state is SHIFT.
- IDLE with start=0: hold all outputs at their last values.
- SHIFT, once per cycle:
  - x = a_sr[0], y = b_sr[0], w = borrow FF;
  - d = x ^ y ^ w;
  - w_next = (~x & y) | (~x & w) | (y & w);
  - a_sr and b_sr shift right by one;
  - result shift register takes d at bit N-1 and shifts right, so after N shifts bit 0 holds the LSB;
  - borrow FF <= w_next;
  - counter increments.
- SHIFT -> DONE transition: on the cycle the counter reaches N-1, the next state is DONE. SHIFT therefore lasts exactly N cycles.
- Entering DONE:
  - diff <= result register;
  - bout <= final borrow;
  - ovf <= (a_sign != b_sign) & (diff[N-1] != a_sign);
  - done=1 for exactly one cycle.
- busy = 1 only in SHIFT.
- Latency: start sampled at edge k, done=1 during the cycle after edge k+N+1. Throughput is one operation per N+2 cycles.
- start while busy or done is high: ignored. Operand inputs are don't-care outside the IDLE start cycle.
- diff, bout and ovf are stable from done until the next accepted start completes. During SHIFT the previous result remains visible.
- Wrap-around: the result is always modulo 2^N; a negative unsigned result is signalled only via bout.
- Counter width: ceil(log2(N)) bits; it must not alias for N a power of two.

Test Plan:
- N=8: a=200, b=55, pulse start -> busy for 8 cycles; done at cycle 10; diff=145, bout=0, ovf=0.
- N=8: a=5, b=10 -> diff=251 (0xFB), bout=1, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- N=8: a=0, b=0 -> diff=0, bout=0, ovf=0. Then a=0xFF, b=0xFF -> diff=0, bout=0.
- Hold start=1 continuously with changing a and b -> operations start only from IDLE. Each result matches the operands latched at acceptance; done pulses are exactly N+2 cycles apart.
- Assert reset for one cycle at SHIFT cycle 4 of a=100, b=1 -> next cycle all outputs are 0, state IDLE, no done. A subsequent start with a=9, b=3 yields diff=6.
- Random sweep, 1000 pairs at N=8 and N=5, checked against a reference model for diff, bout, ovf and done timing.
